kgp_muldiv: RTL
===============

KGP_MULDIV -- requirements
Module: kgp_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand width in bits (legal values 8 to 64).
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
REQ-006 The block SHALL have port a, input, WIDTH bits, multiplicand or dividend.
REQ-007 The block SHALL have port b, input, WIDTH bits, multiplier or divisor.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an operation is in flight.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port hi, output, WIDTH bits: product upper half, or remainder.
REQ-011 The block SHALL have port lo, output, WIDTH bits: product lower half, or quotient.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit, set with done when a divide has b == 0.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE, start=1 at edge k SHALL latch op, a and b, convert signed operands to magnitudes, and enter CALC; busy SHALL be 1 from edge k.
REQ-015 CALC SHALL run exactly WIDTH cycles, one shift-add (mul) or shift-subtract restoring step (div) per cycle, using a cycle counter of clog2(WIDTH)+1 bits.
REQ-016 FIX SHALL take one cycle to apply sign correction and load hi/lo.
REQ-017 DONE SHALL assert done=1 for exactly one cycle and deassert busy, then return to IDLE; done SHALL rise at edge k+WIDTH+2.
REQ-018 start while busy=1 SHALL be ignored; the operands and op of the in-flight operation SHALL be unaffected.
REQ-019 start sampled in the DONE cycle SHALL be ignored; a new operation SHALL be accepted no earlier than the following cycle.
REQ-020 Mul: {hi,lo} SHALL equal the full 2*WIDTH-bit product, two's complement for op=01.
REQ-021 Signed div: the quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-022 Signed div of the most negative value by -1 SHALL give lo = most negative value and hi = 0, with no flag.
REQ-023 Div with b == 0 SHALL skip CALC, go IDLE->FIX->DONE, give lo = all ones, hi = a and div_by_zero = 1, with done at edge k+2.
REQ-024 div_by_zero SHALL be cleared when the next operation is accepted.
REQ-025 hi, lo and div_by_zero SHALL hold their values from DONE until the next accepted start, then hold until the next FIX.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, with busy=0, done=0, hi=0, lo=0, div_by_zero=0 and the counter cleared, regardless of clock.
REQ-027 Reset asserted mid-operation SHALL abort the operation without producing a done pulse; after release the block SHALL accept start on the first rising edge.

Verification
REQ-028 WIDTH=32, op=00, a=0xFFFFFFFF, b=0xFFFFFFFF -> at k+34: done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 op=01, a=-7, b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6 (-42), done at k+34.
REQ-030 op=11, a=-7, b=2 -> lo=-3, hi=-1; then op=11, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-031 op=10, a=123, b=0 -> done at k+2, div_by_zero=1, lo=0xFFFFFFFF, hi=123; the next op=10, a=100, b=7 -> lo=14, hi=2, div_by_zero=0.
REQ-032 start pulsed at k+5 with different operands during busy -> the result equals the first operation, with exactly one done pulse.
REQ-033 rst=0 at k+10 mid-divide -> busy=0 and hi=lo=0 immediately with no done pulse; after release a new op=00, a=3, b=5 -> lo=15.
REQ-034 WIDTH=8 instance, op=01, a=0x80, b=0x80 -> hi=0x40, lo=0x00, done at k+10.

Source files
------------

// File: rtl/kgp_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, rst (async active-low), start/op/a/b in; busy, done, hi, lo, div_by_zero out.
module kgp_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t           st;
  logic [CW-1:0]    cnt;
  logic             isdiv;
  logic             dz;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] opd;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shf;
  logic [WIDTH+1:0] dif;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_n;

  assign a_neg  = op[0] & a[WIDTH-1];
  assign b_neg  = op[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  // sr holds the multiplier (mul) or dividend/quotient (div)
  assign msum = {1'b0, acc} + {1'b0, (sr[0] ? opd : '0)};
  assign shf  = {acc, sr[WIDTH-1]};
  // borrow in the top bit means the trial subtract must be undone
  assign dif  = {1'b0, shf} - {2'b00, opd};

  assign prod   = {acc, sr};
  assign prod_n = -prod;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      cnt         <= '0;
      isdiv       <= 1'b0;
      dz          <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      sr          <= '0;
      opd         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (start) begin
            isdiv       <= op[1];
            dz          <= op[1] & b_zero;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            acc         <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (op[1]) begin
              sr  <= a_mag;
              opd <= b_mag;
            end else begin
              sr  <= b_mag;
              opd <= a_mag;
            end
            st <= (op[1] && b_zero) ? FIX : CALC;
          end
        end
        CALC: begin
          if (isdiv) begin
            acc <= dif[WIDTH+1] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
            sr  <= {sr[WIDTH-2:0], ~dif[WIDTH+1]};
          end else begin
            acc <= msum[WIDTH:1];
            sr  <= {msum[0], sr[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
          if (cnt == LAST) st <= FIX;
        end
        FIX: begin
          if (dz) begin
            // sr still holds |a|; restore the caller's dividend
            hi <= neg_r ? -sr : sr;
            lo <= '1;
          end else if (isdiv) begin
            hi <= neg_r ? -acc : acc;
            lo <= neg_q ? -sr : sr;
          end else begin
            {hi, lo} <= neg_q ? prod_n : prod;
          end
          st <= DONE;
        end
        DONE: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dz;
          st          <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
